// File: rtl/liteic_pkg.sv
// Shared types and constants for the lite interconnect write path.
package liteic_pkg;

  localparam int IC_NUM_MASTER_SLOTS = 4;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_XFER = 2'd1,
    WR_RESP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/liteic_priority_cd.sv
// Fixed-priority encoder: reports the index of the lowest set bit of in.
module liteic_priority_cd #(
  parameter int W  = 8,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  in,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from the top so the lowest set bit is the last one written and wins
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (in[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/liteic_rr_select.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// The request vector is doubled: the low half keeps only bits at or above ptr,
// the high half is the full vector, so a plain lowest-bit priority encoder
// finds the wrapped winner.
module liteic_rr_select #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] id,
  output logic          valid
);

  localparam int DW  = 2 * N;
  localparam int DIW = $clog2(DW);

  logic [N-1:0]   mask;
  logic [DW-1:0]  dbl_req;
  logic [DIW-1:0] pidx;

  // Keep only the request bits at or after the round-robin pointer
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (IW'(i) >= ptr);
    end
  end

  assign dbl_req = {req, req & mask};

  liteic_priority_cd #(
    .W  (DW),
    .IW (DIW)
  ) u_prio (
    .in    (dbl_req),
    .idx   (pidx),
    .valid (valid)
  );

  // Fold the double-width index back into the master range and decode it
  always_comb begin
    if (pidx >= DIW'(N)) begin
      id = IW'(pidx - DIW'(N));
    end else begin
      id = IW'(pidx);
    end
    onehot = valid ? (N'(1) << id) : '0;
  end

endmodule

// File: rtl/liteic_wr_arbiter.sv
// Write-path arbiter: grants one master at a time round-robin and sequences
// its AW/W forwarding, then the B response, before releasing the grant.
module liteic_wr_arbiter
  import liteic_pkg::*;
#(
  parameter int NUM_MST = liteic_pkg::IC_NUM_MASTER_SLOTS,
  parameter int ID_W    = $clog2(NUM_MST)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_MST-1:0] req_i,
  input  logic               aw_hs_i,
  input  logic               w_hs_i,
  input  logic               b_hs_i,
  output logic               grant_val_o,
  output logic [NUM_MST-1:0] grant_onehot_o,
  output logic [ID_W-1:0]    grant_id_o,
  output logic               aw_en_o,
  output logic               w_en_o,
  output logic               b_en_o
);

  wr_state_e           state_r, state_d;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     grant_id_r;
  logic                aw_done_r, w_done_r;
  logic [NUM_MST-1:0]  sel_onehot;
  logic [ID_W-1:0]     sel_id;
  logic                sel_valid;
  logic                aw_fire, w_fire;
  logic [ID_W-1:0]     ptr_next;

  liteic_rr_select #(
    .N  (NUM_MST),
    .IW (ID_W)
  ) u_rr_select (
    .req    (req_i),
    .ptr    (rr_ptr),
    .onehot (sel_onehot),
    .id     (sel_id),
    .valid  (sel_valid)
  );

  // Handshakes only count while their channel is enabled
  assign aw_fire  = (state_r == WR_XFER) && aw_hs_i && !aw_done_r;
  assign w_fire   = (state_r == WR_XFER) && w_hs_i && !w_done_r;
  assign ptr_next = (grant_id_r == ID_W'(NUM_MST - 1)) ? '0 : grant_id_r + 1'b1;

  // Next-state selection and outputs decoded from state and held registers
  always_comb begin
    state_d        = state_r;
    grant_val_o    = 1'b0;
    grant_onehot_o = '0;
    grant_id_o     = '0;
    aw_en_o        = 1'b0;
    w_en_o         = 1'b0;
    b_en_o         = 1'b0;
    case (state_r)
      WR_IDLE: begin
        if (sel_valid) begin
          state_d = WR_XFER;
        end
      end
      WR_XFER: begin
        grant_val_o    = 1'b1;
        grant_id_o     = grant_id_r;
        grant_onehot_o = NUM_MST'(1) << grant_id_r;
        aw_en_o        = !aw_done_r;
        w_en_o         = !w_done_r;
        if ((aw_done_r || aw_fire) && (w_done_r || w_fire)) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        grant_val_o    = 1'b1;
        grant_id_o     = grant_id_r;
        grant_onehot_o = NUM_MST'(1) << grant_id_r;
        b_en_o         = 1'b1;
        if (b_hs_i) begin
          state_d = WR_IDLE;
        end
      end
      default: begin
        state_d = WR_IDLE;
      end
    endcase
  end

  // State, grant latch, done flags and round-robin pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= WR_IDLE;
      rr_ptr     <= '0;
      grant_id_r <= '0;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
    end else begin
      state_r <= state_d;
      if (state_r == WR_IDLE && sel_valid) begin
        grant_id_r <= sel_id;
      end
      if (aw_fire) begin
        aw_done_r <= 1'b1;
      end
      if (w_fire) begin
        w_done_r <= 1'b1;
      end
      if (state_r == WR_RESP && b_hs_i) begin
        rr_ptr     <= ptr_next;
        grant_id_r <= '0;
        aw_done_r  <= 1'b0;
        w_done_r   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/liteic_wr_arbiter.md
LITEIC_WR_ARBITER -- requirements
Module: liteic_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_MST, default liteic_pkg::IC_NUM_MASTER_SLOTS, number of requesting master slots (≥2).
REQ-002 SHALL have parameter ID_W, default $clog2(NUM_MST), width of the granted master index.
REQ-003 SHALL have one clock and a synchronous active-high reset; all state changes only on the rising edge of clk_i.
REQ-004 SHALL have port clk_i, input, 1, clock.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_i, input, NUM_MST, per-master AW valid.
REQ-007 SHALL have port aw_hs_i, input, 1, slave-side AW valid&ready this cycle.
REQ-008 SHALL have port w_hs_i, input, 1, slave-side W valid&ready this cycle.
REQ-009 SHALL have port b_hs_i, input, 1, slave-side B valid&ready this cycle.
REQ-010 SHALL have port grant_val_o, output, 1, a grant is held.
REQ-011 SHALL have port grant_onehot_o, output, NUM_MST, one-hot granted master; zero when grant_val_o is 0.
REQ-012 SHALL have port grant_id_o, output, ID_W, binary index of the granted master; zero when grant_val_o is 0.
REQ-013 SHALL have port aw_en_o, output, 1, AW channel may be forwarded.
REQ-014 SHALL have port w_en_o, output, 1, W channel may be forwarded.
REQ-015 SHALL have port b_en_o, output, 1, B channel may be forwarded.

Function
REQ-016 SHALL implement an FSM with states IDLE, XFER and RESP; all outputs are registered or decoded only from state and registers.
REQ-017 In IDLE with |req_i == 1, the block SHALL pick the first set bit at or after rr_ptr, wrapping modulo NUM_MST, and latch it; the next cycle it SHALL be in XFER with grant_val_o = 1 (1-cycle grant latency).
REQ-018 In IDLE with req_i == 0, the block SHALL stay in IDLE with no grant.
REQ-019 In XFER:
- aw_en_o = !aw_done_r and w_en_o = !w_done_r.
- aw_hs_i sets aw_done_r and w_hs_i sets w_done_r.
- A handshake input SHALL be ignored while its enable is low.
REQ-020 XFER SHALL go to RESP on the cycle where (aw_done_r | aw_hs_i) & (w_done_r | w_hs_i); simultaneous AW/W handshakes, in either order, SHALL be accepted.
REQ-021 In RESP: b_en_o = 1 and aw_en_o = w_en_o = 0.
REQ-022 On b_hs_i in RESP, the block SHALL go to IDLE, clear the grant and both done flags, and set rr_ptr = (grant_id + 1) mod NUM_MST, with wrap from NUM_MST-1 to 0.
REQ-023 b_hs_i outside RESP SHALL be ignored.
REQ-024 Once latched, the grant SHALL NOT change until the B handshake, even if req_i of the granted or any other master drops or changes.
REQ-025 IDLE SHALL last at least one cycle between transactions, giving a minimum of 3 cycles per write.
REQ-026 With all masters requesting continuously, grants SHALL rotate 0,1,…,NUM_MST-1,0; no master waits more than NUM_MST-1 transactions.

Reset
REQ-027 rst_i SHALL force, on the next edge:
- state = IDLE and rr_ptr = 0
- aw_done_r = w_done_r = 0
- grant_val_o = 0, grant_onehot_o = 0, grant_id_o = 0
- aw_en_o = w_en_o = b_en_o = 0
REQ-028 Reset asserted mid-transaction, in XFER or RESP, SHALL abandon the transaction with no partial state retained.

Structure
REQ-029 The FSM state enum type SHALL be defined in liteic_pkg.
REQ-030 Round-robin selection SHALL be a sub-module liteic_rr_select:
- combinational; inputs req and ptr; outputs onehot and id.
- Implemented as a double-width mask-and-priority scheme reusing liteic_priority_cd.

Verification
REQ-031 NUM_MST=4; reset; req_i=4'b0100 -> grant_id_o=2, grant_onehot_o=4'b0100 one cycle later; aw_en_o=w_en_o=1.
REQ-032 req_i=4'b1111 held, each transaction completed with aw_hs, w_hs then b_hs -> grant sequence 0,1,2,3,0.
REQ-033 In XFER, assert w_hs_i alone, then aw_hs_i two cycles later -> w_en_o drops after w_hs; RESP is entered the cycle after aw_hs_i.
REQ-034 aw_hs_i and w_hs_i in the same cycle -> RESP next cycle, b_en_o=1; b_hs_i -> IDLE, rr_ptr=grant_id+1.
REQ-035 Grant to master 3, then drop req_i[3] during XFER -> grant unchanged; after b_hs_i, rr_ptr wraps to 0.
REQ-036 rst_i asserted in RESP -> all outputs 0 the next cycle; the next request from master 1 is granted id 1, as rr_ptr is 0.
